regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and sequencer for the RV32I register file's single write port. It accepts write requests from up to NUM_REQ producers (ALU, load unit, CSR/system path) through valid/ready handshakes and grants one per cycle in round-robin order. It drives the register file's `rd`, `rd_write_control` and `rd_write_val` from a registered output stage. Optionally, after reset it sequences a zero-fill sweep of x1..x31 before opening the port to requesters.

## Interface
- NUM_REQ, 3: number of write-back requesters, legal range 2..8.
- GW, $clog2(NUM_REQ): width of the grant index.

- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_rd  in  NUM_REQ*5  destination register; requester k occupies bits [5k+4:5k].
- req_val  in  NUM_REQ*32  write data; requester k occupies bits [32k+31:32k].
- req_ready  out  NUM_REQ  combinational grant; one-hot or zero.
- rd  out  5  register-file write address (registered).
- rd_write_control  out  1  register-file write enable (registered).
- rd_write_val  out  32  register-file write data (registered).
- grant_id  out  GW  index of the requester whose write is on the port (registered).
- init_done  out  1  high once the port is open to requesters.

## Operation
- FSM states:
  - INIT: zero-fill sweep; present only with WB_INIT_SWEEP_EN.
  - RUN: arbitration.
- Reset values:
  - rd = 0, rd_write_control = 0, rd_write_val = 0, grant_id = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Sweep counter = 1.
  - init_done = 0 when WB_INIT_SWEEP_EN is defined, otherwise 1.
- INIT:
  - req_ready = 0.
  - Each cycle the output register loads rd = counter, rd_write_control = 1, rd_write_val = 0, grant_id = 0.
  - The counter increments from 1 to 31.
  - After the x31 load, the next edge enters RUN and sets init_done = 1.
- RUN arbitration:
  - Candidates are requesters with req_valid high, searched starting at pointer+1 modulo NUM_REQ.
  - The first candidate found is the winner; req_ready is high for the winner only.
  - Accept means req_valid[k] && req_ready[k].
  - On accept, the pointer is set to k.
  - On accept, the output register loads rd = req_rd[k], rd_write_val = req_val[k], grant_id = k.
  - On accept, rd_write_control = (req_rd[k] != 0): writes to x0 are consumed but never issued.
- No accept in a cycle: rd_write_control loads 0; rd, rd_write_val and grant_id hold their previous values; the pointer holds.
- Requesters may drop req_valid without having been accepted. A requester that is not granted keeps its data and must hold it stable while req_valid is high.
- In RUN, req_ready never depends on rd_write_control or any downstream state: the register file always accepts a write.

## Timing
- Latency: a request accepted in cycle N appears on the port in cycle N+1. The register file captures it at the rising edge that ends cycle N+1.
- Throughput: one accept per cycle. A single continuously valid requester is accepted every cycle.
- Fairness: with all requesters valid, grants rotate 0,1,...,NUM_REQ-1,0,... and each requester waits at most NUM_REQ-1 cycles.
- Sweep timing:
  - The x1 load occurs at the first rising edge after i_rst deasserts; x31 is loaded at edge 31.
  - init_done rises at edge 32, and req_ready may be high in that same cycle.
  - The first requester write reaches the port at edge 33.
- Reset mid-operation, applied asynchronously:
  - Outputs clear to their reset values immediately.
  - A write accepted before reset but not yet captured is lost.
  - A sweep in progress restarts from x1 after reset release.
- All req_valid bits low in RUN: req_ready = 0 and rd_write_control = 0 on the next cycle.

## Configuration
- WB_INIT_SWEEP_EN defined: the INIT state and sweep counter exist, and the 31-cycle zero-fill runs after every reset release. This guarantees x1..x31 = 0 independent of the register file's own reset behaviour.
- WB_INIT_SWEEP_EN undefined: INIT, the counter and the sweep logic are removed. The FSM resets directly into RUN, init_done is tied to 1, and req_ready may be high in the first cycle after reset.

## Test plan
- Sweep (macro on): release reset -> rd_write_control = 1 with rd = 1..31 and rd_write_val = 0 on edges 1..31; init_done = 1 at edge 32; req_ready = 0 throughout the sweep.
- Latency (macro on or off): requester 1 alone, req_rd = 5, req_val = 0xDEADBEEF, accepted in cycle N -> in cycle N+1: rd = 5, rd_write_val = 0xDEADBEEF, rd_write_control = 1, grant_id = 1.
- Round-robin: all three requesters valid for 6 cycles after reset -> grant_id sequence on the port is 0,1,2,0,1,2 and exactly one req_ready bit is high each cycle.
- x0 discard: requester 2 writes req_rd = 0, req_val = 0x12345678 -> req_ready[2] = 1 for one cycle and rd_write_control stays 0.
- Idle hold: an accepted write to x7 followed by no requests -> rd_write_control = 0 next cycle, while rd = 7 and rd_write_val are held.
- Reset mid-stream: assert i_rst while a write to x9 is registered on the port -> rd_write_control = 0 immediately. With the macro on, the sweep restarts at rd = 1 after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the RV32I register file write port.
// Round-robin grant over NUM_REQ valid/ready requesters, registered port.
// Optional macro WB_INIT_SWEEP_EN: zero-fill x1..x31 after every reset.
// Ports: i_clk, i_rst (async, active-low); req_valid/req_rd/req_val in,
//   req_ready out (comb, one-hot or zero); rd, rd_write_control,
//   rd_write_val, grant_id (registered); init_done (port open).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*5-1:0]  req_rd,
    input  logic [NUM_REQ*32-1:0] req_val,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [4:0]            rd,
    output logic                  rd_write_control,
    output logic [31:0]           rd_write_val,
    output logic [GW-1:0]         grant_id,
    output logic                  init_done
);

    logic [4:0]  rd_arr  [NUM_REQ];
    logic [31:0] val_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rd_arr[g]  = req_rd[5*g +: 5];
        assign val_arr[g] = req_val[32*g +: 32];
    end

    logic [GW-1:0] ptr_q, ptr_d;
    logic [4:0]    rd_q, rd_d;
    logic          wen_q, wen_d;
    logic [31:0]   val_q, val_d;
    logic [GW-1:0] gid_q, gid_d;

    logic          run;
    logic          found;
    logic          accept;
    logic [GW-1:0] win;

`ifdef WB_INIT_SWEEP_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       init_done_q, init_done_d;

    assign run       = (state_q == ST_RUN);
    assign init_done = init_done_q;
`else
    assign run       = 1'b1;
    assign init_done = 1'b1;
`endif

    // Search begins one past the last winner, wrapping at NUM_REQ.
    always_comb begin
        int s;
        s     = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            s = int'(ptr_q) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (!found && req_valid[s[GW-1:0]]) begin
                found = 1'b1;
                win   = s[GW-1:0];
            end
        end
    end

    assign accept = run && found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        rd_d  = rd_q;
        val_d = val_q;
        gid_d = gid_q;
        wen_d = 1'b0;
`ifdef WB_INIT_SWEEP_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            // Counter runs past 31 by one so the open edge is idle.
            if (cnt_q == 6'd32) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end else begin
                rd_d  = cnt_q[4:0];
                wen_d = 1'b1;
                val_d = '0;
                gid_d = '0;
                cnt_d = cnt_q + 6'd1;
            end
        end
`endif
        if (accept) begin
            ptr_d = win;
            rd_d  = rd_arr[win];
            val_d = val_arr[win];
            gid_d = win;
            // x0 writes are consumed but never reach the file.
            wen_d = (rd_arr[win] != 5'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q       <= GW'(NUM_REQ - 1);
            rd_q        <= '0;
            wen_q       <= 1'b0;
            val_q       <= '0;
            gid_q       <= '0;
`ifdef WB_INIT_SWEEP_EN
            state_q     <= ST_INIT;
            cnt_q       <= 6'd1;
            init_done_q <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            val_q       <= val_d;
            gid_q       <= gid_d;
`ifdef WB_INIT_SWEEP_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
`endif
        end
    end

    assign rd               = rd_q;
    assign rd_write_control = wen_q;
    assign rd_write_val     = val_q;
    assign grant_id         = gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (NUM_REQ = 3).
// Stimulus pushes expected port writes; a negedge monitor pops them.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [1:0]  gid;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [4:0]  trd [3];
    logic [31:0] tval [3];
    logic [14:0] req_rd;
    logic [95:0] req_val;
    logic [2:0]  req_ready;
    logic [4:0]  rd;
    logic        rd_write_control;
    logic [31:0] rd_write_val;
    logic [1:0]  grant_id;
    logic        init_done;

    wr_t q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    assign req_rd  = {trd[2], trd[1], trd[0]};
    assign req_val = {tval[2], tval[1], tval[0]};

    always #5 i_clk = ~i_clk;

    regfile_wb_arbiter #(.NUM_REQ(3)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .req_valid        (req_valid),
        .req_rd           (req_rd),
        .req_val          (req_val),
        .req_ready        (req_ready),
        .rd               (rd),
        .rd_write_control (rd_write_control),
        .rd_write_val     (rd_write_val),
        .grant_id         (grant_id),
        .init_done        (init_done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every issued write must match the oldest expected one.
    always @(negedge i_clk) begin
        if (i_rst === 1'b1 && rd_write_control === 1'b1) begin
            if (q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d val=%h expected none",
                         rd, rd_write_val);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("port_rd", 32'(rd), 32'(e.rd));
                chk("port_val", rd_write_val, e.val);
                chk("port_gid", 32'(grant_id), 32'(e.gid));
            end
        end
    end

    task automatic cyc(input logic [2:0] v,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [2:0] er);
        @(posedge i_clk);
        #1;
        req_valid = v;
        trd[0] = r0; trd[1] = r1; trd[2] = r2;
        tval[0] = d0; tval[1] = d1; tval[2] = d2;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        for (int k = 0; k < 3; k++)
            if (er[k] && trd[k] != 5'd0)
                q.push_back(wr_t'{rd: trd[k], val: tval[k], gid: 2'(k)});
    endtask

    task automatic idle();
        cyc(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        req_valid = '0;
        q.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_rd", 32'(rd), 32'h0);
        chk("rst_wen", 32'(rd_write_control), 32'h0);
        chk("rst_val", rd_write_val, 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
`ifdef WB_INIT_SWEEP_EN
        chk("rst_init_done", 32'(init_done), 32'h0);
        i_rst = 1'b1;
        for (int r = 1; r <= 31; r++)
            q.push_back(wr_t'{rd: 5'(r), val: 32'h0, gid: 2'd0});
        for (int e = 1; e <= 32; e++) begin
            @(posedge i_clk);
            #1;
            if (e < 32) begin
                req_valid = 3'b111;
                #1;
                chk("sweep_ready", 32'(req_ready), 32'h0);
                chk("sweep_init_done", 32'(init_done), 32'h0);
            end else begin
                req_valid = 3'b000;
                chk("open_init_done", 32'(init_done), 32'h1);
            end
        end
`else
        chk("rst_init_done", 32'(init_done), 32'h1);
        i_rst = 1'b1;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            trd[k]  = '0;
            tval[k] = '0;
        end
        do_reset();

        // Latency: requester 1 alone.
        cyc(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010);
        idle();
        chk("lat_rd", 32'(rd), 32'd5);
        chk("lat_wen", 32'(rd_write_control), 32'h1);
        chk("lat_gid", 32'(grant_id), 32'd1);

        // Round-robin from reset: 0,1,2,0,1,2.
        do_reset();
        for (int c = 0; c < 6; c++)
            cyc(3'b111, 5'd10, 5'd11, 5'd12,
                32'hA0 + 32'(c), 32'hB0 + 32'(c), 32'hC0 + 32'(c),
                3'b001 << (c % 3));
        // Pointer at 2: requester 0 idle, so 1 wins over 2.
        cyc(3'b110, 5'd0, 5'd13, 5'd14, 32'h0, 32'h1313, 32'h1414, 3'b010);
        // Pointer at 1: 2 wins over 0.
        cyc(3'b101, 5'd15, 5'd0, 5'd16, 32'h1515, 32'h0, 32'h1616, 3'b100);

        // x0 discard from requester 2 (pointer at 2, so 0 gets checked first).
        cyc(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h12345678, 3'b100);
        idle();
        chk("x0_wen", 32'(rd_write_control), 32'h0);

        // Idle hold after a write to x7.
        cyc(3'b001, 5'd7, 5'd0, 5'd0, 32'h00000777, 32'h0, 32'h0, 3'b001);
        idle();
        @(posedge i_clk);
        #1;
        chk("hold_wen", 32'(rd_write_control), 32'h0);
        chk("hold_rd", 32'(rd), 32'd7);
        chk("hold_val", rd_write_val, 32'h00000777);

        // Reset while x9 is on the port.
        cyc(3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 3'b001);
        @(posedge i_clk);
        #1;
        req_valid = 3'b000;
        #1;
        chk("pre_rst_wen", 32'(rd_write_control), 32'h1);
        chk("pre_rst_rd", 32'(rd), 32'd9);
        i_rst = 1'b0;
        #1;
        chk("async_rst_wen", 32'(rd_write_control), 32'h0);
        chk("async_rst_rd", 32'(rd), 32'h0);
        do_reset();

        // Port open again; pointer back at NUM_REQ-1.
        cyc(3'b110, 5'd0, 5'd3, 5'd4, 32'h0, 32'h33, 32'h44, 3'b010);
        idle();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("queue_empty", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
